// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver state encoding, the default bit period for a
// 50 MHz clock at 9600 baud, and a helper that derives the mid-bit
// sample point from a bit period.
package uart_rx_pkg;

  // 50 MHz / 9600 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // Mid-bit offset measured from the first clock of a bit.
  function automatic int unsigned half_count(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk   in  1  sampling clock
//   rst   in  1  asynchronous active-low reset
//   d     in  1  asynchronous input
//   q     out 1  synchronised output (two clocks of latency)
// Both flops reset to RESET_VAL so the output shows a sensible idle value
// immediately after reset.
module uart_rx_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver, LSB first, mid-bit sampling.
// Ports:
//   clk        in  1  system clock, rising edge
//   rst        in  1  asynchronous active-low reset
//   rx         in  1  serial line, idle high, asynchronous to clk
//   rx_data    out 8  last correctly framed byte, held until the next one
//   rx_valid   out 1  one-cycle pulse when rx_data has just been updated
//   frame_err  out 1  one-cycle pulse when the stop bit sampled low
//   rx_busy    out 1  high whenever the receiver is not idle
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_count(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_rx_sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;

  // The timer restarts on every state change and on every completed data
  // bit, so each bit is measured from its own first clock. The stop bit is
  // judged at its midpoint and the FSM returns to IDLE straight away, which
  // leaves half a bit of margin to catch an immediately following start bit.
  // A low stop bit parks the FSM in BREAK until the line goes high again, so
  // a held-low line is not mistaken for a stream of start bits.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with an 8-clock bit period.
// Stimulus pushes the expected receiver events into a queue; a monitor pops
// and compares whenever the receiver reports a byte or a framing error.
// One clock period is 100 time units so fractional bit timings stay integral.
module tb_uart_rx;

  localparam int CLK_PERIOD = 100;
  localparam int BIT_TIME   = 8 * CLK_PERIOD;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  typedef struct packed {
    logic       isErr;
    logic [7:0] data;
  } exp_t;

  exp_t       expQ[$];
  int         validCycles[$];
  int         checks;
  int         errors;
  int         cycleCnt;
  logic [7:0] prevGood;

  uart_rx #(
    .CLKS_PER_BIT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  // Free-running clock and a cycle counter used for latency and spacing.
  initial clk = 1'b0;
  always #(CLK_PERIOD / 2) clk = ~clk;

  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Drives the first nbits of a frame (bit 0 first) with the given bit time.
  task automatic applyStimulus(input logic [9:0] frame, input int nbits, input int bitTime);
    for (int i = 0; i < nbits; i++) begin
      rx = frame[i];
      #(bitTime);
    end
  endtask

  function automatic logic [9:0] makeFrame(input logic [7:0] data, input logic stopBit);
    return {stopBit, data, 1'b0};
  endfunction

  task automatic expectByte(input logic [7:0] data);
    exp_t e;
    e.isErr = 1'b0;
    e.data  = data;
    expQ.push_back(e);
    prevGood = data;
  endtask

  task automatic expectFrameErr();
    exp_t e;
    e.isErr = 1'b1;
    e.data  = prevGood;
    expQ.push_back(e);
  endtask

  // Places the next input change just after a falling edge.
  task automatic alignDrive();
    @(negedge clk);
    #10;
  endtask

  task automatic idleBits(input int n);
    rx = 1'b1;
    #(n * BIT_TIME);
  endtask

  // Bounded wait for every queued expectation to be consumed.
  task automatic waitDrain(input string name);
    int budget;
    budget = 300;
    while (expQ.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput(name, expQ.size(), 0);
    expQ.delete();
  endtask

  // Scoreboard monitor: compares every receiver event against the queue.
  always @(negedge clk) begin
    if (rst && (rx_valid || frame_err)) begin
      exp_t e;
      checkOutput("valid_err_exclusive", {31'b0, rx_valid & frame_err}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("pending_expectations", 32'd0, 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("event_is_err", {31'b0, frame_err}, {31'b0, e.isErr});
        checkOutput("rx_data", {24'b0, rx_data}, {24'b0, e.data});
        if (rx_valid) validCycles.push_back(cycleCnt);
      end
    end
  end

  initial begin
    int fallCycle;
    int base;
    int busyCnt;

    checks   = 0;
    errors   = 0;
    prevGood = 8'h00;
    rx       = 1'b1;
    rst      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_rx_data", {24'b0, rx_data}, 32'h00);
    checkOutput("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
    checkOutput("reset_frame_err", {31'b0, frame_err}, 32'd0);
    checkOutput("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
    #10;
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 1. Single byte 0xA5 with exact timing, plus start-to-valid latency
    $display("[TB] test 1: single byte 0xA5");
    alignDrive();
    expectByte(8'hA5);
    base      = validCycles.size();
    fallCycle = cycleCnt;
    applyStimulus(makeFrame(8'hA5, 1'b1), 10, BIT_TIME);
    waitDrain("t1_drain");
    checkOutput("t1_one_valid", validCycles.size() - base, 1);
    if (validCycles.size() > base) begin
      int lat;
      lat = validCycles[base] - fallCycle;
      checkOutput("t1_latency_in_range", {31'b0, (lat >= 78 && lat <= 80)}, 32'd1);
    end
    idleBits(1);
    checkOutput("t1_busy_after", {31'b0, rx_busy}, 32'd0);

    // 2. Back-to-back 0x00, 0xFF, 0x55 with no idle gap
    $display("[TB] test 2: back-to-back frames");
    alignDrive();
    base = validCycles.size();
    expectByte(8'h00);
    applyStimulus(makeFrame(8'h00, 1'b1), 10, BIT_TIME);
    expectByte(8'hFF);
    applyStimulus(makeFrame(8'hFF, 1'b1), 10, BIT_TIME);
    expectByte(8'h55);
    applyStimulus(makeFrame(8'h55, 1'b1), 10, BIT_TIME);
    waitDrain("t2_drain");
    checkOutput("t2_three_valid", validCycles.size() - base, 3);
    if (validCycles.size() >= base + 3) begin
      checkOutput("t2_spacing_1", validCycles[base+1] - validCycles[base], 80);
      checkOutput("t2_spacing_2", validCycles[base+2] - validCycles[base+1], 80);
    end
    idleBits(1);

    // 3. Two-clock glitch on an idle line
    $display("[TB] test 3: start-bit glitch");
    alignDrive();
    base    = validCycles.size();
    busyCnt = 0;
    rx      = 1'b0;
    #(2 * CLK_PERIOD - 10);
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_busy) busyCnt++;
    end
    checkOutput("t3_busy_short", {31'b0, (busyCnt > 0 && busyCnt < 6)}, 32'd1);
    checkOutput("t3_no_valid", validCycles.size() - base, 0);
    checkOutput("t3_no_pending", expQ.size(), 0);

    // 4. Bad stop bit, line held low, then a good frame
    $display("[TB] test 4: framing error and break");
    alignDrive();
    expectFrameErr();
    applyStimulus(makeFrame(8'h3C, 1'b0), 10, BIT_TIME);
    rx = 1'b0;
    #(40 * CLK_PERIOD);
    checkOutput("t4_busy_in_break", {31'b0, rx_busy}, 32'd1);
    checkOutput("t4_data_held", {24'b0, rx_data}, 32'h55);
    checkOutput("t4_err_consumed", expQ.size(), 0);
    idleBits(2);
    alignDrive();
    expectByte(8'h81);
    applyStimulus(makeFrame(8'h81, 1'b1), 10, BIT_TIME);
    waitDrain("t4_drain");
    idleBits(1);

    // 5. Reset in the middle of the data bits of 0x7E
    $display("[TB] test 5: reset mid-frame");
    alignDrive();
    applyStimulus(makeFrame(8'h7E, 1'b1), 5, BIT_TIME);
    checkOutput("t5_busy_before_reset", {31'b0, rx_busy}, 32'd1);
    rst = 1'b0;
    rx  = 1'b1;
    #5;
    checkOutput("t5_async_rx_data", {24'b0, rx_data}, 32'h00);
    checkOutput("t5_async_rx_busy", {31'b0, rx_busy}, 32'd0);
    checkOutput("t5_async_rx_valid", {31'b0, rx_valid}, 32'd0);
    checkOutput("t5_async_frame_err", {31'b0, frame_err}, 32'd0);
    prevGood = 8'h00;
    repeat (3) @(negedge clk);
    #10;
    rst = 1'b1;
    idleBits(2);
    alignDrive();
    expectByte(8'h12);
    applyStimulus(makeFrame(8'h12, 1'b1), 10, BIT_TIME);
    waitDrain("t5_drain");
    idleBits(1);

    // 6. Sender bit period skewed by +3% and -3%
    $display("[TB] test 6: baud skew");
    alignDrive();
    expectByte(8'hC3);
    applyStimulus(makeFrame(8'hC3, 1'b1), 10, 825);
    waitDrain("t6_slow_drain");
    idleBits(2);
    alignDrive();
    expectByte(8'hC3);
    applyStimulus(makeFrame(8'hC3, 1'b1), 10, 775);
    waitDrain("t6_fast_drain");
    idleBits(2);
    checkOutput("final_rx_data", {24'b0, rx_data}, 32'hC3);
    checkOutput("final_rx_busy", {31'b0, rx_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
